// File: rtl/nibble_add_seq.sv
// nibble_add_seq -- sequential W-bit adder that runs through an external
// registered 4-bit CLA stage, one nibble at a time, LSB nibble first.
//
// Each nibble takes three cycles:
//   ISSUE - drive the operands
//   WAIT  - wait for the stage's internal register
//   CAPT  - capture the stage's sum and carry
// A full add takes 3*NIBBLES cycles from accept to out_valid.
//
// Ports
//   clk, rst_n                  clock; synchronous active-low reset
//   in_valid/in_ready           operand request handshake
//   in_a, in_b, in_cin          W-bit operands and carry-in
//   add_a, add_b, add_cin       nibble operands to the CLA stage
//   add_s, add_cout             CLA stage results, sampled only in CAPT
//   out_valid/out_ready         result handshake
//   out_sum, out_cout           W-bit sum (mod 2^W) and carry-out
//   out_ovf                     two's-complement overflow
//                               (only present with NIBBLE_ADD_SEQ_OVF_EN)
//
// Optional feature macro: NIBBLE_ADD_SEQ_OVF_EN
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_cout
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    ,
    output logic                 out_ovf
`endif
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, DONE} state_t;

    state_t state, state_nxt;

    logic [NIBBLES-1:0][3:0] a_reg, b_reg, sum_reg;
    logic                    carry_reg;
    logic [IW-1:0]           idx;
    logic                    last_nib;

    assign last_nib = (idx == IW'(NIBBLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = CAPT;
            CAPT:    state_nxt = last_nib ? DONE : ISSUE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath. add_s/add_cout are looked at only in CAPT, so whatever is
    // left in the stage after a reset or between nibbles is never taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg     <= in_a;
                    b_reg     <= in_b;
                    carry_reg <= in_cin;
                    idx       <= '0;
                end
                CAPT: begin
                    sum_reg[idx] <= add_s;
                    carry_reg    <= add_cout;
                    if (!last_nib) idx <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated with rst_n so they read zero while reset is held,
    // even in the cycle before the reset edge takes effect.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = rst_n && (state == DONE);
    assign out_sum   = rst_n ? sum_reg : '0;
    assign out_cout  = rst_n && carry_reg;

    // idx only changes at the end of CAPT, so the operands stay steady
    // across ISSUE, WAIT and CAPT of the same nibble.
    assign add_a   = rst_n ? a_reg[idx] : 4'h0;
    assign add_b   = rst_n ? b_reg[idx] : 4'h0;
    assign add_cin = rst_n && carry_reg;

`ifdef NIBBLE_ADD_SEQ_OVF_EN
    // Overflow: both operands have the same sign,
    // but the result's sign differs from it.
    assign out_ovf = rst_n
                  && (a_reg[NIBBLES-1][3] == b_reg[NIBBLES-1][3])
                  && (sum_reg[NIBBLES-1][3] != a_reg[NIBBLES-1][3]);
`endif

endmodule

// File: tb/tb_nibble_add_seq.sv
// Testbench for nibble_add_seq (NIBBLES=4). It models the downstream
// registered CLA stage as a two-deep register pipeline, and compares results
// against plain integer addition of the operands.
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0, in_b = '0;
    logic        in_cin = 1'b0;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    logic        out_ovf;
`endif

    int tests = 0;
    int fails = 0;

    logic [3:0] obs_a   [0:99];
    logic [3:0] obs_b   [0:99];
    logic       obs_cin [0:99];
    logic       obs_rdy [0:99];

    nibble_add_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Downstream registered 4-bit CLA stage: a two-register pipeline
    logic [4:0] st1 = '0, st2 = '0;
    always @(posedge clk) begin
        st1 <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
        st2 <= st1;
    end
    assign add_s    = st2[3:0];
    assign add_cout = st2[4];

    // Reference model: the full 17-bit sum of the operands
    function automatic logic [16:0] ref_sum(input logic [15:0] a, b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {16'b0, cin};
    endfunction

    // Carry into nibble k, taken from the sum of the lower 4k bits
    function automatic logic ref_nib_cin(input logic [15:0] a, b, input logic cin, input int k);
        int unsigned m, lo;
        m  = (32'd1 << (4 * k)) - 1;
        lo = (a & m) + (b & m) + cin;
        return lo[4*k];
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        logic [15:0] t;
        t = v >> (4 * k);
        return t[3:0];
    endfunction

    // Runs one transaction and returns what it observed. It checks nothing itself.
    task automatic do_txn(input logic [15:0] a, b, input logic cin, input int stall,
                          output int lat, output logic [15:0] sum, output logic cout,
                          output logic stable, output logic rdy_low);
        int n;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 99) begin
            obs_a[lat] = add_a; obs_b[lat] = add_b;
            obs_cin[lat] = add_cin; obs_rdy[lat] = in_ready;
            @(posedge clk); #1;
            lat++;
        end
        sum = out_sum; cout = out_cout; stable = 1'b1; rdy_low = 1'b1;
        repeat (stall) begin
            @(posedge clk); #1;
            if (!out_valid || out_sum !== sum || out_cout !== cout) stable = 1'b0;
            if (in_ready) rdy_low = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_a = 16'hA5A5; in_b = 16'h5A5A;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        tests++; if (out_sum !== 16'h0)  begin fails++; $display("FAIL rst_out_sum got %h want 0000", out_sum); end
        tests++; if (out_cout !== 1'b0)  begin fails++; $display("FAIL rst_out_cout got %0b want 0", out_cout); end
        tests++; if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
            fails++; $display("FAIL rst_add got a=%h b=%h cin=%0b want 0", add_a, add_b, add_cin);
        end
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL rst_out_ovf got %0b want 0", out_ovf); end
`endif
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_ripple();
        int lat; logic [15:0] s; logic c, st, rl;
        do_txn(16'hFFFF, 16'h0001, 1'b0, 0, lat, s, c, st, rl);
        tests++; if (lat != 12)    begin fails++; $display("FAIL ripple_latency got %0d want 12", lat); end
        tests++; if (s !== 16'h0)  begin fails++; $display("FAIL ripple_sum got %h want 0000", s); end
        tests++; if (c !== 1'b1)   begin fails++; $display("FAIL ripple_cout got %0b want 1", c); end
    endtask

    task automatic test_cin();
        int lat; logic [15:0] s; logic c, st, rl;
        do_txn(16'h1234, 16'h4321, 1'b1, 0, lat, s, c, st, rl);
        tests++; if (s !== 16'h5556) begin fails++; $display("FAIL cin_sum got %h want 5556", s); end
        tests++; if (c !== 1'b0)     begin fails++; $display("FAIL cin_cout got %0b want 0", c); end
        for (int k = 0; k < 12 && k < lat; k++) begin
            tests++;
            if (obs_cin[k] !== (k < 3)) begin
                fails++; $display("FAIL cin_add_cin cycle %0d got %0b want %0b", k, obs_cin[k], (k < 3));
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [15:0] a, b, s; logic cin, c, st, rl;
        logic [16:0] r;
        int bad;
        for (int t = 0; t < 25; t++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            if (t == 0) begin a = 16'h0000; b = 16'h0000; cin = 1'b0; end
            if (t == 1) begin a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; end
            do_txn(a, b, cin, int'($urandom_range(0, 3)), lat, s, c, st, rl);
            r = ref_sum(a, b, cin);
            tests++; if (lat != 12) begin fails++; $display("FAIL rand_latency t%0d got %0d want 12", t, lat); end
            tests++; if (s !== r[15:0] || c !== r[16]) begin
                fails++; $display("FAIL rand_result t%0d %h+%h+%0b got %0b_%h want %0b_%h", t, a, b, cin, c, s, r[16], r[15:0]);
            end
            bad = 0;
            for (int k = 0; k < 12 && k < lat; k++) begin
                if (obs_a[k] !== nib(a, k / 3) || obs_b[k] !== nib(b, k / 3) ||
                    obs_cin[k] !== ref_nib_cin(a, b, cin, k / 3) || obs_rdy[k] !== 1'b0) bad++;
            end
            tests++; if (bad != 0) begin fails++; $display("FAIL rand_nibble_ops t%0d got %0d bad cycles want 0", t, bad); end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] s; logic c, st, rl;
        do_txn(16'h0F0F, 16'h0101, 1'b0, 5, lat, s, c, st, rl);
        tests++; if (st !== 1'b1)    begin fails++; $display("FAIL bp_stable got %0b want 1", st); end
        tests++; if (rl !== 1'b1)    begin fails++; $display("FAIL bp_in_ready_low got %0b want 1", rl); end
        tests++; if (s !== 16'h1010) begin fails++; $display("FAIL bp_sum got %h want 1010", s); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] s; logic c, st, rl;
        int seen;
        in_a = 16'h89AB; in_b = 16'h7654; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
        tests++; if (seen != 0) begin fails++; $display("FAIL midrst_no_out_valid got %0d want 0", seen); end
        do_txn(16'h0001, 16'h0001, 1'b0, 0, lat, s, c, st, rl);
        tests++; if (s !== 16'h0002 || c !== 1'b0) begin
            fails++; $display("FAIL midrst_next_sum got %0b_%h want 0_0002", c, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a[2], b[2]; logic ci[2];
        int acc[2], hs[2], na, nh;
        logic [15:0] s[2]; logic c[2];
        logic [16:0] r;
        a[0] = 16'($urandom); b[0] = 16'($urandom); ci[0] = 1'b0;
        a[1] = 16'($urandom); b[1] = 16'($urandom); ci[1] = 1'b1;
        acc = '{0, 0}; hs = '{0, 0}; s = '{16'h0, 16'h0}; c = '{1'b0, 1'b0};
        na = 0; nh = 0;
        in_a = a[0]; in_b = b[0]; in_cin = ci[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && nh < 2; cyc++) begin
            if (in_valid && in_ready && na < 2) begin acc[na] = cyc; na++; end
            if (out_valid) begin hs[nh] = cyc; s[nh] = out_sum; c[nh] = out_cout; nh++; end
            @(posedge clk); #1;
            if (na == 1) begin in_a = a[1]; in_b = b[1]; in_cin = ci[1]; end
            if (na == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests++; if (nh != 2) begin fails++; $display("FAIL b2b_results got %0d want 2", nh); end
        tests++; if (acc[1] != hs[0] + 1) begin
            fails++; $display("FAIL b2b_second_accept got cycle %0d want %0d", acc[1], hs[0] + 1);
        end
        for (int k = 0; k < 2; k++) begin
            r = ref_sum(a[k], b[k], ci[k]);
            tests++; if (s[k] !== r[15:0] || c[k] !== r[16]) begin
                fails++; $display("FAIL b2b_result%0d got %0b_%h want %0b_%h", k, c[k], s[k], r[16], r[15:0]);
            end
        end
    endtask

`ifdef NIBBLE_ADD_SEQ_OVF_EN
    task automatic test_ovf();
        int lat; logic [15:0] s; logic c, st, rl;
        in_valid = 1'b0;
        in_a = 16'h7FFF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
        while (!in_ready) begin @(posedge clk); #1; end
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        tests++; if (out_sum !== 16'h8000 || out_cout !== 1'b0 || out_ovf !== 1'b1) begin
            fails++; $display("FAIL ovf_pos got sum=%h cout=%0b ovf=%0b want 8000 0 1", out_sum, out_cout, out_ovf);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        in_a = 16'hFFFF; in_b = 16'h0001; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        tests++; if (out_valid !== 1'b1 || out_ovf !== 1'b0) begin
            fails++; $display("FAIL ovf_neg got valid=%0b ovf=%0b want 1 0", out_valid, out_ovf);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ripple();
        test_cin();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: operand width in nibbles (W = 4*NIBBLES); legal range 1..16.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_a (in, W), in_b (in, W) and in_cin (in, 1): operand request channel.
REQ-005 SHALL have ports add_a (out, 4), add_b (out, 4) and add_cin (out, 1): nibble operands to the downstream registered 4-bit CLA stage.
REQ-006 SHALL have ports add_s (in, 4) and add_cout (in, 1): results returned by that stage, 2 clk edges after operand capture.
REQ-007 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_sum (out, W) and out_cout (out, 1): result channel.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, CAPT and DONE.
REQ-009 SHALL assert in_ready only in IDLE; in_valid&&in_ready latches in_a, in_b and in_cin, clears nibble index i to 0, and moves to ISSUE.
REQ-010 SHALL drive add_a=a_reg[4i+3:4i], add_b=b_reg[4i+3:4i] and add_cin=carry_reg, held constant through the ISSUE, WAIT and CAPT cycles of nibble i.
REQ-011 SHALL set carry_reg to in_cin at accept and to add_cout at each CAPT.
REQ-012 SHALL sequence ISSUE->WAIT->CAPT unconditionally, one cycle each.
REQ-013 SHALL, at the end of CAPT, write add_s into sum_reg[4i+3:4i] and capture add_cout.
REQ-014 SHALL, at the end of CAPT, increment i and go to ISSUE if i<NIBBLES-1, else go to DONE.
REQ-015 SHALL assert out_valid in DONE only, with out_sum=sum_reg and out_cout = final carry, stable while out_valid&&!out_ready.
REQ-016 SHALL, on out_valid&&out_ready, move to IDLE, making in_ready=1 the following cycle; a new request is never accepted in the DONE cycle.
REQ-017 SHALL assert out_valid exactly 3*NIBBLES rising edges after the accept edge (12 for NIBBLES=4).
REQ-018 SHALL ignore in_valid outside IDLE and ignore add_s/add_cout outside CAPT.
REQ-019 SHALL wrap the result modulo 2^W, with any carry beyond bit W-1 reported only on out_cout.

Reset
REQ-020 SHALL, on any edge with rst_n=0, go to IDLE and clear a_reg, b_reg, sum_reg, carry_reg and i.
REQ-021 SHALL hold outputs during reset at in_ready=0, out_valid=0, out_sum=0, out_cout=0, add_a=0, add_b=0 and add_cin=0.
REQ-022 SHALL drive in_ready=1 on the first cycle after rst_n returns high.
REQ-023 SHALL, on reset mid-transaction (any state), silently discard the transaction: no out_valid results from it, and stale add_s values are never captured.

Configuration
REQ-024 SHALL, with macro NIBBLE_ADD_SEQ_OVF_EN defined, add port out_ovf (out, 1), valid with out_valid.
REQ-025 SHALL compute out_ovf = (a_reg[W-1]==b_reg[W-1]) && (sum_reg[W-1]!=a_reg[W-1]), i.e. two's-complement overflow.
REQ-026 SHALL reset out_ovf to 0.
REQ-027 SHALL, without NIBBLE_ADD_SEQ_OVF_EN, omit port out_ovf and its logic, with all other behaviour identical.

Verification
REQ-028 Carry ripple: in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x0000, out_cout=1, out_valid 12 edges after accept.
REQ-029 Carry-in use: in_a=0x1234, in_b=0x4321, in_cin=1 -> out_sum=0x5556, out_cout=0; add_cin=1 on nibble 0 only.
REQ-030 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_cout stable; in_ready=0 throughout; release -> in_ready=1 the next cycle.
REQ-031 Reset mid-op: rst_n=0 for 1 edge at cycle 5 after accept -> IDLE, in_ready=1 next cycle; out_valid never asserts; a following 0x0001+0x0001 gives 0x0002.
REQ-032 Overflow (macro on): in_a=0x7FFF, in_b=0x0001 -> out_sum=0x8000, out_ovf=1, out_cout=0; 0xFFFF+0x0001 -> out_ovf=0.
REQ-033 Back-to-back: in_valid held high across two requests -> second accepted exactly one cycle after the first out handshake; both results correct.
